// File: rtl/f1_start_ctrl_if.sv
// Handshake bundle between the race-start sequencer and its environment.
// The sequencer connects through the slave modport; the driver side uses master.
interface f1_start_ctrl_if #(
  parameter int unsigned RT_W = 16
);
  logic            trigger;
  logic            btn;
  logic [7:0]      lfsr_data;
  logic            lfsr_en;
  logic [7:0]      lights;
  logic            busy;
  logic            done;
  logic [RT_W-1:0] react_time;
  logic            jump_start;

  modport master (
    output trigger, btn, lfsr_data,
    input  lfsr_en, lights, busy, done, react_time, jump_start
  );

  modport slave (
    input  trigger, btn, lfsr_data,
    output lfsr_en, lights, busy, done, react_time, jump_start
  );
endinterface

// File: rtl/f1_start_ctrl.sv
// Race-start sequencer: fills eight lights one per tick, holds for an LFSR-derived
// number of ticks, then times the driver's reaction from lights-out to button press.
module f1_start_ctrl #(
  parameter int unsigned TICK_CYCLES = 4,
  parameter int unsigned RT_W        = 16
) (
  input logic            clk,
  input logic            rst,
  f1_start_ctrl_if.slave bus
);
  localparam int unsigned    TcntW    = $clog2(TICK_CYCLES);
  localparam logic [TcntW-1:0] TickLast = TcntW'(TICK_CYCLES - 1);
  localparam logic [RT_W-1:0]  RtMax    = '1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLights = 2'd1;
  localparam logic [1:0] StHold   = 2'd2;
  localparam logic [1:0] StGo     = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [TcntW-1:0] tcnt_q, tcnt_d;
  logic [7:0]       dly_q, dly_d;
  logic [RT_W-1:0]  rcnt_q, rcnt_d;
  logic [7:0]       lights_q, lights_d;
  logic             done_q, done_d;
  logic [RT_W-1:0]  react_q, react_d;
  logic             jump_q, jump_d;
  logic             timing, tick;

  assign timing = (state_q == StLights) || (state_q == StHold);
  assign tick   = timing && (tcnt_q == TickLast);

  always_comb begin
    state_d  = state_q;
    dly_d    = dly_q;
    rcnt_d   = rcnt_q;
    lights_d = lights_q;
    done_d   = 1'b0;
    react_d  = react_q;
    jump_d   = jump_q;

    unique case (state_q)
      StIdle: begin
        if (bus.trigger) begin
          state_d  = StLights;
          lights_d = 8'h00;
          react_d  = '0;
          jump_d   = 1'b0;
        end
      end
      StLights, StHold: begin
        // An early press wins over any tick landing in the same cycle.
        if (bus.btn) begin
          state_d  = StIdle;
          lights_d = 8'h00;
          react_d  = '0;
          jump_d   = 1'b1;
          done_d   = 1'b1;
        end else if (tick) begin
          if (state_q == StLights) begin
            lights_d = {lights_q[6:0], 1'b1};
            if (lights_q == 8'h7F) begin
              state_d = StHold;
              dly_d   = (bus.lfsr_data == 8'h00) ? 8'd1 : bus.lfsr_data;
            end
          end else if (dly_q == 8'd1) begin
            state_d  = StGo;
            lights_d = 8'h00;
            rcnt_d   = '0;
          end else begin
            dly_d = dly_q - 8'd1;
          end
        end
      end
      StGo: begin
        if (bus.btn) begin
          state_d = StIdle;
          react_d = rcnt_q;
          done_d  = 1'b1;
        end else if (rcnt_q == RtMax) begin
          state_d = StIdle;
          react_d = RtMax;
          done_d  = 1'b1;
        end else begin
          rcnt_d = rcnt_q + RT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Prescaler restarts on every state entry and only runs while lights are timed.
    if ((state_d != state_q) || !timing || tick) begin
      tcnt_d = '0;
    end else begin
      tcnt_d = tcnt_q + TcntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      tcnt_q   <= '0;
      dly_q    <= 8'h00;
      rcnt_q   <= '0;
      lights_q <= 8'h00;
      done_q   <= 1'b0;
      react_q  <= '0;
      jump_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      dly_q    <= dly_d;
      rcnt_q   <= rcnt_d;
      lights_q <= lights_d;
      done_q   <= done_d;
      react_q  <= react_d;
      jump_q   <= jump_d;
    end
  end

  assign bus.lights     = lights_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = done_q;
  assign bus.react_time = react_q;
  assign bus.jump_start = jump_q;
  assign bus.lfsr_en    = (state_q == StIdle) || (state_q == StLights);
endmodule

// File: tb/tb_f1_start_ctrl.sv
// Randomized bench for the race-start sequencer; expectations come from a timeline
// model indexed by cycles since the sequence started.
module tb_f1_start_ctrl;
  localparam int unsigned TICK   = 4;
  localparam int unsigned RTW    = 4;
  localparam int          RT_MAX = 15;
  localparam int          FILL   = 8 * TICK;
  localparam int          NEVER  = 1 << 30;

  logic clk = 1'b0;
  logic rst;

  f1_start_ctrl_if #(.RT_W(RTW)) bus ();

  f1_start_ctrl #(
    .TICK_CYCLES(TICK),
    .RT_W       (RTW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp   = 0;
  int n_err   = 0;
  bit pending = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag, input bit done_e, input int react_e,
                            input bit jump_e);
    check_eq({tag, ".busy"}, 32'(bus.busy), 0);
    check_eq({tag, ".lfsr_en"}, 32'(bus.lfsr_en), 1);
    check_eq({tag, ".lights"}, 32'(bus.lights), 0);
    check_eq({tag, ".done"}, 32'(bus.done), 32'(done_e));
    check_eq({tag, ".react"}, 32'(bus.react_time), 32'(react_e));
    check_eq({tag, ".jump"}, 32'(bus.jump_start), 32'(jump_e));
  endtask

  // One start sequence. is_jump: press at absolute cycle offset (before lights-out);
  // otherwise press offset cycles after lights-out. force_cap<0 keeps lfsr random.
  task automatic run_seq(input bit is_jump, input int offset, input int force_cap,
                         input bit chain, input int rst_at, input string name);
    int        p, e, g, cap, react_e;
    bit        finished;
    logic [7:0] el;
    finished = 1'b0;
    if (!pending) begin
      bus.trigger   = 1'b1;
      bus.btn       = 1'b0;
      bus.lfsr_data = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    pending = 1'b0;
    p = is_jump ? offset : NEVER;
    e = is_jump ? offset : NEVER;
    g = NEVER;
    for (int t = 0; t < 2000; t++) begin
      if (t > e) begin
        finished = 1'b1;
        break;
      end
      if (t < FILL) el = 8'((32'd1 << (t / TICK)) - 32'd1);
      else if (t < g) el = 8'hFF;
      else el = 8'h00;
      check_eq({name, ".lights"}, 32'(bus.lights), 32'(el));
      check_eq({name, ".busy"}, 32'(bus.busy), 1);
      check_eq({name, ".done"}, 32'(bus.done), 0);
      check_eq({name, ".lfsr_en"}, 32'(bus.lfsr_en), 32'(t < FILL));
      check_eq({name, ".react_busy"}, 32'(bus.react_time), 0);
      check_eq({name, ".jump_busy"}, 32'(bus.jump_start), 0);
      if (t == rst_at) begin
        rst         = 1'b1;
        bus.trigger = 1'b0;
        bus.btn     = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_idle({name, ".after_rst"}, 1'b0, 0, 1'b0);
        @(negedge clk);
        check_idle({name, ".after_rst2"}, 1'b0, 0, 1'b0);
        return;
      end
      bus.btn       = (t >= p);
      bus.trigger   = ($urandom_range(0, 3) == 0);
      bus.lfsr_data = (t == FILL - 1 && force_cap >= 0) ? 8'(force_cap)
                                                        : 8'($urandom_range(0, 255));
      if (t == FILL - 1) begin
        cap = int'(bus.lfsr_data);
        g   = FILL + TICK * ((cap == 0) ? 1 : cap);
        if (!is_jump) begin
          p = g + offset;
          e = g + ((offset < RT_MAX) ? offset : RT_MAX);
        end
      end
      @(negedge clk);
    end
    if (!finished) begin
      check_eq({name, ".sequence_ended"}, 0, 1);
      return;
    end
    react_e = is_jump ? 0 : ((offset < RT_MAX) ? offset : RT_MAX);
    check_idle({name, ".result"}, 1'b1, react_e, is_jump);
    bus.btn       = 1'b0;
    bus.trigger   = chain;
    bus.lfsr_data = 8'($urandom_range(0, 255));
    @(negedge clk);
    if (chain) begin
      pending = 1'b1;
    end else begin
      check_idle({name, ".held"}, 1'b0, react_e, is_jump);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.trigger   = 1'b0;
    bus.btn       = 1'b0;
    bus.lfsr_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_idle("reset", 1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bus.lfsr_data = 8'($urandom_range(0, 255));
      @(negedge clk);
      check_idle("idle", 1'b0, 0, 1'b0);
    end

    run_seq(1'b0, 5, 3, 1'b0, -1, "full");
    run_seq(1'b1, 9, -1, 1'b0, -1, "jump");
    run_seq(1'b0, 2, 0, 1'b0, -1, "zero_lfsr");
    run_seq(1'b0, 100, -1, 1'b1, -1, "timeout");
    run_seq(1'b0, 3, -1, 1'b0, -1, "chained");
    for (int i = 0; i < 6; i++) begin
      bit jmp;
      jmp = ($urandom_range(0, 2) == 0);
      run_seq(jmp, jmp ? $urandom_range(0, FILL + TICK - 1) : $urandom_range(0, 20),
              -1, (i < 5) && ($urandom_range(0, 1) == 1), -1, "rand");
    end
    run_seq(1'b0, 0, 200, 1'b0, FILL + 5, "rst_hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/f1_start_ctrl.md
Name: f1_start_ctrl

Overview:
Race-start sequencer for the lab FSM datapath. It drives the 8 start lights one per tick and uses the external 8-bit LFSR as the source of a random hold delay. It then times the driver's reaction from lights-out to button press. The block owns the LFSR enable, so the LFSR free-runs only while the block is idle or filling the lights.

Parameters:
TICK_CYCLES, 4, clk cycles per light/delay tick (>=2); internal prescaler
RT_W, 16, reaction-time counter width

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
trigger  input  1  start request; sampled only in IDLE
btn  input  1  driver button, level, synchronous to clk
lfsr_data  input  8  current LFSR value
lfsr_en  output  1  enable to the LFSR
lights  output  8  start lights; bit0 lit first
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when a result is posted
react_time  output  RT_W  reaction cycles; held until the next trigger
jump_start  output  1  set with done if btn was pressed before lights-out; held until the next trigger

Behaviour:
- Reset, synchronous: state=IDLE; lights=0, busy=0, done=0, react_time=0, jump_start=0; tick count and delay register cleared.
- lfsr_en is combinational: 1 in IDLE and LIGHTS, 0 otherwise.
- Prescaler: tcnt cleared on every state entry. It counts 0..TICK_CYCLES-1 and wraps. tick=1 when tcnt==TICK_CYCLES-1 (LIGHTS/HOLD only).
- IDLE: if trigger, go to LIGHTS at the next edge. At that edge: lights<=0, react_time<=0, jump_start<=0. trigger while busy is ignored; no queuing.
- LIGHTS: on each tick, lights<={lights[6:0],1'b1}.
  - On the tick where lights becomes 8'hFF: go to HOLD and capture dly<=lfsr_data. If lfsr_data==0, load 1.
- HOLD: lights stay 8'hFF.
  - On each tick, dly decrements.
  - On the tick with dly==1: go to GO, lights<=0, rcnt<=0.
  - Total hold is dly*TICK_CYCLES cycles.
- GO: lights=0. Each cycle with btn=0, rcnt increments.
  - First cycle btn=1: react_time<=rcnt, done<=1, go to IDLE. A press in the first GO cycle gives 0.
  - If rcnt reaches all-ones with btn=0: react_time<=all-ones, done<=1, go to IDLE (timeout).
- Jump start: btn=1 in any LIGHTS or HOLD cycle aborts the sequence. At that edge: jump_start<=1, react_time<=0, lights<=0, done<=1, state<=IDLE. btn takes priority over a coincident tick.
- done is high for exactly one cycle, the first IDLE cycle after the result.
  - trigger in that same cycle is accepted; at that edge react_time and jump_start clear.
- Latency: trigger sampled at edge k; first light visible TICK_CYCLES edges later.
  - Lights-out occurs (8+dly)*TICK_CYCLES cycles after LIGHTS entry.
- rst mid-sequence: returns to IDLE with all outputs zero next cycle; no done pulse.

Test Plan:
1. Reset, then idle: rst=1 for 2 cycles -> lights=0, busy=0, done=0, react_time=0, lfsr_en=1; trigger held 0 -> state stays IDLE.
2. Full run, TICK_CYCLES=4, lfsr_data=8'h03 at capture:
   - trigger 1 cycle -> busy=1; lights step 01,03,07,...,FF, one step per 4 cycles; lfsr_en=0 once FF is reached.
   - Lights go 0 exactly 12 cycles after FF.
   - btn rises in the 6th GO cycle -> react_time=5, done pulses once, jump_start=0, busy=0.
3. Jump start: btn=1 while lights=8'h07 -> next cycle lights=0, jump_start=1, react_time=0, done pulse, IDLE; next trigger clears jump_start.
4. Zero LFSR value: force lfsr_data=0 at capture -> hold is 1 tick (4 cycles) before lights-out.
5. Timeout with RT_W=4: btn never pressed in GO -> after 15 counts react_time=4'hF, done pulse. Also: trigger on the done cycle -> new sequence starts and react_time clears.
6. Reset mid-HOLD, plus trigger while busy:
   - rst=1 mid-HOLD -> next cycle IDLE, lights=0, no done pulse.
   - trigger pulses during LIGHTS -> no effect on the lights sequence.
